// File: rtl/decoder_3to8_seq_if.sv
// Code/handshake/output bundle for the sequenced 3-to-8 decoder.
// master = code producer / indicator consumer, slave = decoder.
interface decoder_3to8_seq_if #(
    parameter int unsigned DEPTH = 4
) ();
    logic [2:0]               Code;
    logic                     code_valid;
    logic                     code_ready;
    logic                     en;
    logic [7:0]               Data;
    logic                     data_valid;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output Code, code_valid, en,
        input  code_ready, Data, data_valid, level
    );

    modport slave (
        input  Code, code_valid, en,
        output code_ready, Data, data_valid, level
    );
endinterface

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: codes are queued in a small FIFO, then each is
// shown one-hot on Data for DWELL cycles followed by a one-cycle blank gap.
module decoder_3to8_seq #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    decoder_3to8_seq_if.slave bus
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [7:0]  CNT_LOAD = 8'(DWELL - 1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [2:0]    code_q, code_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level_q;
    logic          ready, push, pop, fifo_empty;

    assign ready      = (level_q != FULL_LVL);
    assign push       = bus.code_valid && ready;
    assign fifo_empty = (level_q == '0);

    assign bus.code_ready = ready;
    assign bus.Data       = data_q;
    assign bus.data_valid = valid_q;
    assign bus.level      = level_q;

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level_q <= level_q + 1'b1;
            else if (!push && pop)
                level_q <= level_q - 1'b1;
        end
    end

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.Code;
    end

    // Sequencer registers, including the registered one-hot output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Next state, pop request and next output word; en low holds everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        data_d  = data_q;
        valid_d = valid_q;
        pop     = 1'b0;
        if (bus.en) begin
            unique case (state_q)
                IDLE, GAP: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        code_d  = mem[rd_ptr];
                        cnt_d   = CNT_LOAD;
                        state_d = SHOW;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SHOW: begin
                    if (cnt_q != '0)
                        cnt_d = cnt_q - 1'b1;
                    else
                        state_d = GAP;
                end
                default: state_d = IDLE;
            endcase
            valid_d = (state_d == SHOW);
            data_d  = (state_d == SHOW) ? (8'b1 << code_d) : '0;
        end
    end
endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Self-checking bench for decoder_3to8_seq: directed scenarios plus a random
// phase, compared every cycle against a queue/timeline reference model.
module tb_decoder_3to8_seq;
    localparam int unsigned DWELL = 4;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;

    decoder_3to8_seq_if #(.DEPTH(DEPTH)) bus ();

    decoder_3to8_seq #(.DWELL(DWELL), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: queued codes, future output timeline (-1 = blank),
    // and the code currently on display (-1 = blank).
    int mq[$];
    int pend[$];
    int cur = -1;
    bit accepted;

    logic [7:0] watch;
    int watch_hits;
    int valid_hits;

    function automatic int enc8to3(input logic [7:0] d);
        int r = -1;
        for (int i = 0; i < 8; i++)
            if (d[i] === 1'b1) r = i;
        return r;
    endfunction

    function automatic bit model_idle();
        return (mq.size() == 0) && (pend.size() == 0) && (cur < 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance model with pre-edge inputs, clock once, then compare outputs.
    task automatic cycle();
        logic [7:0] exp_data;
        int pc;
        bit can_push;
        accepted = 1'b0;
        if (rst) begin
            mq.delete();
            pend.delete();
            cur = -1;
        end else begin
            can_push = (bus.code_valid === 1'b1) && (mq.size() < DEPTH);
            pc = int'(bus.Code);
            if (bus.en) begin
                if (pend.size() > 0) begin
                    cur = pend.pop_front();
                end else if (mq.size() > 0) begin
                    cur = mq.pop_front();
                    for (int i = 1; i < DWELL; i++) pend.push_back(cur);
                    pend.push_back(-1);
                end else begin
                    cur = -1;
                end
            end
            if (can_push) begin
                mq.push_back(pc);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        exp_data = (cur >= 0) ? 8'(1 << cur) : 8'h00;
        check("data", 32'(bus.Data), 32'(exp_data));
        check("data_valid", 32'(bus.data_valid), (cur >= 0) ? 32'd1 : 32'd0);
        check("level", 32'(bus.level), 32'(mq.size()));
        check("code_ready", 32'(bus.code_ready), (mq.size() < DEPTH) ? 32'd1 : 32'd0);
        if (cur >= 0) check("loopback", 32'(enc8to3(bus.Data)), 32'(cur));
        if (bus.Data === watch) watch_hits++;
        if (bus.data_valid === 1'b1) valid_hits++;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && !model_idle(); i++) cycle();
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        bus.Code = '0;
        bus.code_valid = 1'b0;
        bus.en = 1'b1;
        watch = 8'hFF;
        watch_hits = 0;
        valid_hits = 0;

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_data", 32'(bus.Data), 32'h0);
        check("rst_ready", 32'(bus.code_ready), 32'd1);
        check("rst_level", 32'(bus.level), 32'd0);

        // Single code 5: 8'h20 held for DWELL cycles
        watch = 8'h20;
        watch_hits = 0;
        bus.Code = 3'd5;
        bus.code_valid = 1'b1;
        cycle();
        bus.code_valid = 1'b0;
        check("single_level", 32'(bus.level), 32'd1);
        cycle();
        check("single_first", 32'(bus.Data), 32'h20);
        drain();
        check("single_dwell", 32'(watch_hits), 32'(DWELL));

        // Sweep 0..7 back-to-back
        valid_hits = 0;
        for (int k = 0; k < 8; k++) begin
            bus.Code = 3'(k);
            bus.code_valid = 1'b1;
            accepted = 1'b0;
            for (int t = 0; t < 50 && !accepted; t++) cycle();
            if (!accepted) check("sweep_accept_timeout", 32'd0, 32'd1);
        end
        bus.code_valid = 1'b0;
        drain();
        check("sweep_show_cycles", 32'(valid_hits), 32'(8 * DWELL));

        // Full FIFO with en low
        bus.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.Code = 3'(k + 1);
            bus.code_valid = 1'b1;
            cycle();
        end
        check("full_level", 32'(bus.level), 32'd4);
        check("full_ready", 32'(bus.code_ready), 32'd0);
        bus.Code = 3'd6;
        cycle();
        cycle();
        check("full_hold_level", 32'(bus.level), 32'd4);
        bus.en = 1'b1;
        cycle();
        check("full_first_pop", 32'(bus.level), 32'd3);
        cycle();
        check("full_fifth_in", 32'(bus.level), 32'd4);
        bus.code_valid = 1'b0;
        drain();

        // Enable freeze during SHOW of code 2
        watch = 8'h04;
        watch_hits = 0;
        bus.Code = 3'd2;
        bus.code_valid = 1'b1;
        cycle();
        bus.code_valid = 1'b0;
        cycle();
        cycle();
        bus.en = 1'b0;
        repeat (3) cycle();
        bus.en = 1'b1;
        drain();
        check("freeze_show_cycles", 32'(watch_hits), 32'(DWELL + 3));

        // Reset mid-SHOW with two entries queued
        bus.code_valid = 1'b1;
        bus.Code = 3'd1; cycle();
        bus.Code = 3'd3; cycle();
        bus.Code = 3'd7; cycle();
        bus.code_valid = 1'b0;
        check("pre_rst_level", 32'(bus.level), 32'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_data", 32'(bus.Data), 32'h0);
        check("mid_rst_valid", 32'(bus.data_valid), 32'd0);
        check("mid_rst_level", 32'(bus.level), 32'd0);
        check("mid_rst_ready", 32'(bus.code_ready), 32'd1);
        valid_hits = 0;
        repeat (15) cycle();
        check("post_rst_silent", 32'(valid_hits), 32'd0);

        // Random traffic
        watch = 8'hFF;
        for (int i = 0; i < 600; i++) begin
            bus.Code = 3'($urandom_range(0, 7));
            bus.code_valid = ($urandom_range(0, 99) < 45);
            bus.en = ($urandom_range(0, 99) < 80);
            rst = ($urandom_range(0, 99) < 2);
            cycle();
        end
        rst = 1'b0;
        bus.en = 1'b1;
        bus.code_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
